opti_sos_feeder: RTL and testbench

- Upstream driver for the biquad section's sample interface: sends exactly one single-cycle data_in/valid_in strobe per sample.
- Accepts samples from a ready/valid stream into a small FIFO and issues them one at a time.
- After each strobe, waits for the section's valid_out and forwards its data_out downstream; enforces a minimum idle gap before the next strobe so the feedback delay line settles.
- Detects lost responses (timeout) and unexpected responses (spurious).

---
 rtl/opti_pkg.sv | 20 ++
 rtl/opti_sync_fifo.sv | 57 +++++
 rtl/opti_sos_feeder.sv | 127 ++++++++++++
 tb/tb_opti_sos_feeder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opti_pkg.sv
// Shared definitions for the biquad-section feeder.
//   DW_DEF          default sample width
//   feeder_state_e  feeder FSM states
//   cnt_w()         width of a counter able to hold 0..n inclusive
package opti_pkg;

    localparam int DW_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } feeder_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/opti_sync_fifo.sv
// Synchronous FIFO, registered occupancy, single clock.
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write request (ignored when full)
//   pop            read request (ignored when empty); rdata is the current head
//   full, empty    derived from the registered level
//   level          occupancy, 0..DEPTH
module opti_sync_fifo
    import opti_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = cnt_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opti_sos_feeder.sv
// Upstream driver for a biquad section: buffers a ready/valid sample stream,
// issues one single-cycle strobe per sample, forwards the section's response,
// then idles MIN_GAP cycles so the section's delay line settles.
//   clk, rst                     clock, synchronous active-high reset
//   s_data, s_valid, s_ready     input stream (s_ready = !full)
//   sos_data_in, sos_valid_in    strobe to the section
//   sos_data_out, sos_valid_out  response from the section
//   m_data, m_valid              forwarded response, one-cycle pulse
//   fifo_level, busy             status
//   timeout_err, spurious_err    sticky error flags, cleared by clear_err
module opti_sos_feeder
    import opti_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = 8,
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DW-1:0]          sos_data_in,
    output logic                   sos_valid_in,
    input  logic [DW-1:0]          sos_data_out,
    input  logic                   sos_valid_out,
    output logic [DW-1:0]          m_data,
    output logic                   m_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   spurious_err,
    input  logic                   clear_err
);

    localparam int TW = cnt_w(TIMEOUT);
    localparam int GW = cnt_w(MIN_GAP);

    feeder_state_e state;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] head;
    logic          full;
    logic          empty;
    logic          timeout_set;
    logic          spurious_set;

    opti_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata (s_data),
        .pop   (state == ST_ISSUE),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign s_ready = !full;
    assign busy    = (state != ST_IDLE);

    // Any response outside the wait window is unexpected, including one that
    // lands on the strobe cycle itself or one left over from before a reset.
    always_comb begin
        timeout_set  = (state == ST_WAIT) && !sos_valid_out && (timer == TW'(TIMEOUT - 1));
        spurious_set = sos_valid_out && (state != ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            gap_cnt      <= '0;
            sos_valid_in <= 1'b0;
            sos_data_in  <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            sos_valid_in <= 1'b0;
            m_valid      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Strobe and data are registered together on entry to ISSUE;
                    // sos_data_in then holds until the next issue.
                    if (!empty) begin
                        state        <= ST_ISSUE;
                        sos_valid_in <= 1'b1;
                        sos_data_in  <= head;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sos_valid_out) begin
                        m_data  <= sos_data_out;
                        m_valid <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(MIN_GAP - 1)) state <= ST_IDLE;
                    else                             gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            // A set in the same cycle as clear_err wins.
            if (timeout_set)    timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
            if (spurious_set)   spurious_err <= 1'b1;
            else if (clear_err) spurious_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_opti_sos_feeder.sv
// Self-checking bench for opti_sos_feeder. A responder stands in for the
// biquad section (3-cycle latency, returns sample+1). A timing-window model
// of the feeder is checked every cycle alongside scenario-specific checks.
module tb_opti_sos_feeder;

    localparam int DW      = 24;
    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] sos_data_in;
    logic          sos_valid_in;
    logic [DW-1:0] sos_data_out;
    logic          sos_valid_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic          timeout_err;
    logic          spurious_err;
    logic          clear_err = 1'b0;

    always #5 clk = ~clk;

    opti_sos_feeder #(.DW(DW), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .sos_data_in(sos_data_in), .sos_valid_in(sos_valid_in),
        .sos_data_out(sos_data_out), .sos_valid_out(sos_valid_out),
        .m_data(m_data), .m_valid(m_valid), .fifo_level(fifo_level), .busy(busy),
        .timeout_err(timeout_err), .spurious_err(spurious_err), .clear_err(clear_err)
    );

    // Section stand-in; its pipeline is deliberately untouched by rst.
    logic          resp_en = 1'b1;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    logic [2:0]    rv = '0;
    logic [DW-1:0] rd [3];

    always @(posedge clk) begin
        rv    <= {rv[1:0], sos_valid_in && resp_en};
        rd[0] <= sos_data_in + 1'b1;
        rd[1] <= rd[0];
        rd[2] <= rd[1];
    end
    assign sos_valid_out = rv[2] | inj_v;
    assign sos_data_out  = inj_v ? inj_d : rd[2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: queue contents, response window, error flags.
    bit            model_on = 0;
    int            lvl_m = 0;
    logic [DW-1:0] q_m [$];
    bit            pend_m = 0;
    int            st_c = 0;
    int            end_c = -100;
    bit            prev_st = 0;
    bit            mv_m = 0;
    logic [DW-1:0] md_m = '0;
    bit            to_m = 0;
    bit            sp_m = 0;
    logic [DW-1:0] got_q [$];
    int            st_q [$];

    task automatic model_reset();
        lvl_m = 0; q_m.delete(); pend_m = 0; prev_st = 0; mv_m = 0;
        to_m = 0; sp_m = 0; end_c = -100;
    endtask

    task automatic model_step();
        bit push_ok, set_to, set_sp, nmv;
        if (!model_on) return;
        checks++;
        if (fifo_level !== LW'(lvl_m)) begin failures++;
            $display("FAIL model_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, lvl_m); end
        checks++;
        if (s_ready !== (lvl_m < DEPTH)) begin failures++;
            $display("FAIL model_s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, lvl_m < DEPTH); end
        checks++;
        if (m_valid !== mv_m || (mv_m && m_data !== md_m)) begin failures++;
            $display("FAIL model_m_out cyc=%0d got=%b/%h exp=%b/%h", cyc, m_valid, m_data, mv_m, md_m); end
        checks++;
        if (timeout_err !== to_m || spurious_err !== sp_m) begin failures++;
            $display("FAIL model_flags cyc=%0d got=%b%b exp=%b%b", cyc, timeout_err, spurious_err, to_m, sp_m); end
        if (sos_valid_in === 1'b1) begin
            st_q.push_back(cyc);
            checks++;
            if (q_m.size() == 0 || prev_st || pend_m || cyc < end_c + 2 + MIN_GAP || sos_data_in !== q_m[0]) begin
                failures++;
                $display("FAIL model_strobe cyc=%0d data=%h qsz=%0d prev=%b pend=%b last_end=%0d",
                         cyc, sos_data_in, q_m.size(), prev_st, pend_m, end_c);
            end
        end
        if (m_valid === 1'b1) got_q.push_back(m_data);
        if (rst) begin model_reset(); return; end
        push_ok = s_valid && (lvl_m < DEPTH);
        set_to  = 0;
        set_sp  = sos_valid_out && !pend_m;
        nmv     = 0;
        if (pend_m) begin
            if (sos_valid_out) begin nmv = 1; md_m = sos_data_out; pend_m = 0; end_c = cyc; end
            else if (cyc == st_c + TIMEOUT) begin set_to = 1; pend_m = 0; end_c = cyc; end
        end
        mv_m = nmv;
        if (sos_valid_in === 1'b1) begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (lvl_m > 0) lvl_m--;
            pend_m = 1; st_c = cyc;
        end
        if (push_ok) begin q_m.push_back(s_data); lvl_m++; end
        to_m    = set_to ? 1'b1 : (clear_err ? 1'b0 : to_m);
        sp_m    = set_sp ? 1'b1 : (clear_err ? 1'b0 : sp_m);
        prev_st = sos_valid_in;
    endtask

    // Inputs are driven #1 after posedge; the model samples on the negedge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || fifo_level != 0 || rv != 0 || m_valid) && n < max_cyc) begin tick(); n++; end
        checks++;
        if (n >= max_cyc) begin failures++;
            $display("FAIL wait_idle busy=%b level=%0d required idle within %0d", busy, fifo_level, max_cyc); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        model_reset(); model_on = 1;
        tick();
        rst = 1'b0;
        checks++;
        if (fifo_level !== '0 || s_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_status level=%0d s_ready=%b busy=%b exp 0/1/0", fifo_level, s_ready, busy); end
        checks++;
        if (sos_valid_in !== 1'b0 || sos_data_in !== '0 || m_valid !== 1'b0 || m_data !== '0) begin failures++;
            $display("FAIL reset_outputs svi=%b sdi=%h mv=%b md=%h exp all 0", sos_valid_in, sos_data_in, m_valid, m_data); end
        checks++;
        if (timeout_err !== 1'b0 || spurious_err !== 1'b0) begin failures++;
            $display("FAIL reset_flags to=%b sp=%b exp 0", timeout_err, spurious_err); end
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 24'h000100;
        tick(); s_valid = 1'b0;                       // t+1
        checks++;
        if (sos_valid_in !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", sos_valid_in); end
        tick();                                       // t+2
        checks++;
        if (sos_valid_in !== 1'b1 || sos_data_in !== 24'h000100) begin failures++;
            $display("FAIL single_strobe got=%b/%h exp=1/000100", sos_valid_in, sos_data_in); end
        tick();                                       // t+3
        checks++;
        if (sos_valid_in !== 1'b0 || sos_data_in !== 24'h000100) begin failures++;
            $display("FAIL single_hold got=%b/%h exp=0/000100", sos_valid_in, sos_data_in); end
        repeat (3) tick();                            // t+6
        checks++;
        if (m_valid !== 1'b1 || m_data !== 24'h000101) begin failures++;
            $display("FAIL single_result got=%b/%h exp=1/000101", m_valid, m_data); end
        repeat (3) tick();                            // t+9
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_gap got=%b exp=1", busy); end
        repeat (2) tick();                            // t+11
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        logic [DW-1:0] d [10];
        logic [DW-1:0] e;
        int k = 0;
        int n = 0;
        bit saw_full = 0, saw_reopen = 0;
        got_q.delete(); st_q.delete();
        foreach (d[i]) d[i] = DW'($urandom);
        s_valid = 1'b1; s_data = d[0];
        while (k < 10 && n < 300) begin
            bit acc;
            acc = s_ready;
            if (!s_ready) saw_full = 1;
            if (saw_full && s_ready) saw_reopen = 1;
            tick(); n++;
            if (acc) k++;
            if (k < 10) s_data = d[k]; else s_valid = 1'b0;
        end
        s_valid = 1'b0;
        checks++;
        if (k != 10 || !saw_full || !saw_reopen) begin failures++;
            $display("FAIL burst_accept accepted=%0d full=%b reopen=%b exp 10/1/1", k, saw_full, saw_reopen); end
        n = 0;
        while (got_q.size() < 10 && n < 200) begin tick(); n++; end
        checks++;
        if (got_q.size() != 10) begin failures++;
            $display("FAIL burst_count got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            e = d[i] + 1'b1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, got_q[i], e); end
        end
        for (int i = 1; i < st_q.size(); i++) begin
            checks++;
            if (st_q[i] - st_q[i-1] != 9) begin failures++;
                $display("FAIL burst_spacing[%0d] got=%0d exp=9", i, st_q[i] - st_q[i-1]); end
        end
        wait_idle(100);
    endtask

    task automatic test_timeout();
        int s;
        int n = 0;
        got_q.delete(); st_q.delete();
        resp_en = 1'b0;
        s_valid = 1'b1; s_data = 24'h0000AA;
        tick(); s_data = 24'h0000BB;
        tick(); s_valid = 1'b0;
        checks++;
        if (sos_valid_in !== 1'b1 || sos_data_in !== 24'h0000AA) begin failures++;
            $display("FAIL timeout_strobe got=%b/%h exp=1/0000aa", sos_valid_in, sos_data_in); end
        s = cyc;
        repeat (15) tick();                           // s+15
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", timeout_err); end
        repeat (2) tick();                            // s+17
        checks++;
        if (timeout_err !== 1'b1 || got_q.size() != 0) begin failures++;
            $display("FAIL timeout_flag got=%b results=%0d exp=1/0", timeout_err, got_q.size()); end
        resp_en = 1'b1;
        while (got_q.size() < 1 && n < 60) begin tick(); n++; end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 24'h0000BC) begin failures++;
            $display("FAIL timeout_next results=%0d data=%h exp=1/0000bc", got_q.size(), got_q[0]); end
        checks++;
        if (st_q.size() != 2 || st_q[1] - s != TIMEOUT + 2 + MIN_GAP) begin failures++;
            $display("FAIL timeout_respacing strobes=%0d gap=%0d exp=2/%0d", st_q.size(), st_q[1] - s, TIMEOUT + 2 + MIN_GAP); end
        wait_idle(50);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
    endtask

    task automatic test_spurious();
        logic [DW-1:0] v;
        logic [DW-1:0] e;
        inj_d = DW'($urandom); inj_v = 1'b1;
        tick(); inj_v = 1'b0;
        checks++;
        if (spurious_err !== 1'b1 || m_valid !== 1'b0) begin failures++;
            $display("FAIL spur_idle got=%b/%b exp sp=1 mv=0", spurious_err, m_valid); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        checks++;
        if (spurious_err !== 1'b0 || timeout_err !== 1'b0) begin failures++;
            $display("FAIL spur_clear got=%b/%b exp 0/0", spurious_err, timeout_err); end
        inj_d = DW'($urandom); inj_v = 1'b1; clear_err = 1'b1;
        tick(); inj_v = 1'b0; clear_err = 1'b0;
        checks++;
        if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_set_wins got=%b exp=1", spurious_err); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        // Response on the strobe cycle itself.
        v = DW'($urandom); e = v + 1'b1;
        s_valid = 1'b1; s_data = v;
        tick(); s_valid = 1'b0;
        tick();
        checks++;
        if (sos_valid_in !== 1'b1) begin failures++; $display("FAIL spur_issue_strobe got=%b exp=1", sos_valid_in); end
        inj_d = DW'($urandom); inj_v = 1'b1;
        tick(); inj_v = 1'b0;
        checks++;
        if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_issue got=%b exp=1", spurious_err); end
        repeat (3) tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== e) begin failures++;
            $display("FAIL spur_issue_result got=%b/%h exp=1/%h", m_valid, m_data, e); end
        wait_idle(50);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = DW'($urandom); tick(); end
        s_valid = 1'b0;                               // t+4, waiting for response
        checks++;
        if (busy !== 1'b1 || fifo_level !== LW'(3)) begin failures++;
            $display("FAIL rstmid_pre busy=%b level=%0d exp 1/3", busy, fifo_level); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (fifo_level !== '0 || busy !== 1'b0 || s_ready !== 1'b1 || sos_valid_in !== 1'b0 ||
            sos_data_in !== '0 || m_valid !== 1'b0 || m_data !== '0 || timeout_err !== 1'b0 || spurious_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state level=%0d busy=%b rdy=%b svi=%b sdi=%h mv=%b md=%h to=%b sp=%b exp reset values",
                     fifo_level, busy, s_ready, sos_valid_in, sos_data_in, m_valid, m_data, timeout_err, spurious_err);
        end
        tick();
        checks++;
        if (spurious_err !== 1'b1 || m_valid !== 1'b0) begin failures++;
            $display("FAIL rstmid_late got sp=%b mv=%b exp 1/0", spurious_err, m_valid); end
        wait_idle(30);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
    endtask

    task automatic test_boundary();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] e;
        int n = 0;
        int k = 0;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = DW'($urandom); exp_q.push_back(s_data); tick();
        end
        s_valid = 1'b0;
        while (sos_valid_in !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (sos_valid_in !== 1'b1 || fifo_level !== LW'(7)) begin failures++;
            $display("FAIL bound_pre strobe=%b level=%0d exp 1/7", sos_valid_in, fifo_level); end
        s_valid = 1'b1; s_data = DW'($urandom); exp_q.push_back(s_data);
        tick(); s_valid = 1'b0;
        checks++;
        if (fifo_level !== LW'(7)) begin failures++; $display("FAIL bound_push_pop got=%0d exp=7", fifo_level); end
        n = 0;
        while (k < 20 && n < 2000) begin
            bit acc;
            s_valid = 1'($urandom_range(0, 1)); s_data = DW'($urandom);
            acc = s_valid && s_ready;
            if (acc) exp_q.push_back(s_data);
            tick(); n++;
            if (acc) k++;
        end
        s_valid = 1'b0;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 600) begin tick(); n++; end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            e = exp_q[i] + 1'b1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_q[i], e); end
        end
        wait_idle(50);
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        wait_idle(30);
        test_burst();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
